elastic_pipeline: RTL
=====================

ELASTIC_PIPELINE -- requirements
Module: elastic_pipeline

Interface
REQ-001 Parameter DW, default 64, data width in bits (>=1).
REQ-002 Parameter N, default 16, number of register stages (>=1).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 nreset  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  global advance enable; low = freeze all state.
REQ-006 flush  input  1  synchronous clear of all stage valids.
REQ-007 valid_in  input  1  upstream data valid.
REQ-008 ready_in  output  1  pipeline can accept data_in this cycle.
REQ-009 data_in  input  DW  upstream data.
REQ-010 valid_out  output  1  stage N-1 holds valid data.
REQ-011 ready_out  input  1  downstream accepts data_out this cycle.
REQ-012 data_out  output  DW  stage N-1 data register.
REQ-013 count  output  $clog2(N+1)  number of valid stages (0..N).

Function
REQ-014 Each stage i (0..N-1) SHALL hold a data register and a valid bit; stage 0 is fed from data_in, stage N-1 drives valid_out/data_out directly (registered outputs).
REQ-015 drain[N-1] SHALL be en & valid[N-1] & ready_out; drain[i<N-1] SHALL be en & valid[i] & open[i+1].
REQ-016 open[i] SHALL be ~valid[i] | drain[i] (bubble-collapsing: a stage loads when empty or emptying this cycle).
REQ-017 ready_in SHALL be en & ~flush & open[0]; input transfer SHALL occur when valid_in & ready_in.
REQ-018 Output transfer SHALL occur only when en & valid_out & ready_out; ready_out with en low SHALL NOT consume data.
REQ-019 On transfer into stage i the data register SHALL load; otherwise it SHALL hold (no data toggling on idle stages).
REQ-020 valid[i] next SHALL be 1 when loaded, 0 when drained and not reloaded, else hold.
REQ-021 Latency SHALL be exactly N cycles through an empty, unstalled pipe: accepted at edge t, valid_out high after edge t+N-1 ... i.e. observable in cycle t+N.
REQ-022 With ready_out held high and en high, throughput SHALL be one transfer per cycle with no bubbles inserted.
REQ-023 With ready_out low, data SHALL compact toward stage N-1; ready_in SHALL fall only when all N stages are valid (count==N).
REQ-024 Full pipe with ready_out high SHALL accept and emit in the same cycle (count unchanged).
REQ-025 count SHALL increment on input-only transfer, decrement on output-only transfer, hold on both or neither; never exceed N or drop below 0.
REQ-026 flush high at an edge SHALL clear all valid bits and count to 0, overriding en and any same-cycle transfer; data registers SHALL hold; output transfer in the flush cycle SHALL still count as consumed by downstream.
REQ-027 en low SHALL hold all valid, data and count; valid_out/data_out stay stable.
REQ-028 N=1 SHALL degenerate to a single full-throughput register slice with combinational ready_in from ready_out.

Reset
REQ-029 nreset low SHALL asynchronously clear all valid bits and count; valid_out=0, ready_in follows en & ~flush (1 when enabled).
REQ-030 Data registers SHALL NOT be reset; data_out is don't-care while valid_out=0.
REQ-031 Reset asserted mid-transfer SHALL discard all in-flight data; first post-release accept SHALL see latency N.

Structure
REQ-032 A shared package SHALL hold the count-width function (clog2 of N+1) used by this block and consumers.
REQ-033 One sub-module elastic_stage (valid bit + DW data register + load/drain logic) SHALL be instantiated N times via generate.

Verification
REQ-034 Reset, en=1, ready_out=1, valid_in pulse with data_in=0xA5 (N=16) -> valid_out/data_out=0xA5 exactly 16 cycles later, count 1 during flight.
REQ-035 Continuous valid_in with incrementing data, ready_out=1 -> one output per cycle, sequence 0,1,2,... gap-free, count steady at 16.
REQ-036 ready_out=0, feed 20 words -> ready_in drops after 16th accept, count=16; raise ready_out -> words 0..15 emitted in order, then 16..19.
REQ-037 Pipe holding 5 words, flush pulse -> count=0, valid_out=0 next cycle; subsequent word emerges after 16 cycles.
REQ-038 Stream in progress, en low 3 cycles -> all outputs frozen, no loss/duplication; order preserved after en returns.
REQ-039 Random valid_in/ready_out/en (N=1 and N=16) -> scoreboard in-order match, count equals outstanding words every cycle.

Source files
------------

// File: rtl/elastic_pipeline_pkg.sv
// Shared definitions for the elastic pipeline and its consumers.
package elastic_pipeline_pkg;

  // Width of an occupancy counter that must represent 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/elastic_pipeline_stage.sv
// One elastic slot: valid bit plus data register. The slot accepts new data
// when it is empty or is handing its current word downstream in the same cycle.
module elastic_stage #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          en,
  input  logic          flush,
  input  logic          load,
  input  logic          open_nxt,
  input  logic [DW-1:0] d,
  output logic          valid,
  output logic          open_o,
  output logic [DW-1:0] q
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          drain;

  assign drain  = en & valid_q & open_nxt;
  assign open_o = ~valid_q | drain;
  assign valid  = valid_q;
  assign q      = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load && !flush) data_d = d;
    if (flush)      valid_d = 1'b0;
    else if (load)  valid_d = 1'b1;
    else if (drain) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) valid_q <= 1'b0;
    else         valid_q <= valid_d;
  end

  // Data has no reset: it is only meaningful while valid_q is set.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/elastic_pipeline.sv
// N-deep bubble-collapsing valid/ready pipeline with global enable, flush and
// occupancy count. The ready path is a combinational chain from ready_out back to ready_in.
module elastic_pipeline
  import elastic_pipeline_pkg::*;
#(
  parameter int DW = 64,
  parameter int N  = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [DW-1:0]        data_in,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [DW-1:0]        data_out,
  output logic [cnt_w(N)-1:0]  count
);

  localparam int CW = cnt_w(N);

  logic [N-1:0] vld;
  logic         in_xfer;

  assign in_xfer = valid_in & ready_in;

  for (genvar i = 0; i < N; i++) begin : g_stg
    logic          load;
    logic          open_nxt;
    logic          open_o;
    logic [DW-1:0] d;
    logic [DW-1:0] q;

    if (i == 0) begin : g_head
      assign load = in_xfer;
      assign d    = data_in;
    end else begin : g_body
      // Upstream stage drains exactly when it is valid and this stage is open.
      assign load = en & vld[i-1] & open_o;
      assign d    = g_stg[i-1].q;
    end

    if (i == N - 1) begin : g_tail
      assign open_nxt = ready_out;
    end else begin : g_mid
      assign open_nxt = g_stg[i+1].open_o;
    end

    elastic_stage #(.DW(DW)) u_stage (
      .clk      (clk),
      .nreset   (nreset),
      .en       (en),
      .flush    (flush),
      .load     (load),
      .open_nxt (open_nxt),
      .d        (d),
      .valid    (vld[i]),
      .open_o   (open_o),
      .q        (q)
    );
  end

  assign ready_in  = en & ~flush & g_stg[0].open_o;
  assign valid_out = vld[N-1];
  assign data_out  = g_stg[N-1].q;

  // Occupancy is the population of valid bits, so it follows every
  // load/drain/flush/reset exactly and can never leave 0..N.
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) count = count + CW'(vld[i]);
  end

endmodule
